// File: rtl/tff_count_sequencer_if.sv
// Control/bank-side signal bundle for the T_FF count sequencer.
// master = control logic plus the T_FF bank; slave = the sequencer itself.
interface tff_count_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] q_vec;
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_val;
  logic             dir;
  logic             one_shot;
  logic [WIDTH-1:0] t_vec;
  logic             tff_clear;
  logic             busy;
  logic             done;

  modport master (
    output q_vec, start, stop, load, load_val, mod_val, dir, one_shot,
    input  t_vec, tff_clear, busy, done
  );

  modport slave (
    input  q_vec, start, stop, load, load_val, mod_val, dir, one_shot,
    output t_vec, tff_clear, busy, done
  );
endinterface

// File: rtl/tff_count_sequencer.sv
// Sequencer for a bank of T_FF cells acting as a programmable modulo counter.
// The count lives in the bank; this block only computes per-cell toggle
// enables from the bank's q outputs and its own latched configuration.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  tff_count_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [WIDTH:0] ONE      = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] FULL_MOD = {1'b1, {WIDTH{1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             dir_q, dir_d;
  logic             one_shot_q, one_shot_d;
  logic [WIDTH-1:0] load_q, load_d;

  // Count arithmetic is one bit wider so M = 2**WIDTH and M-1 never overflow.
  logic [WIDTH:0] m_ext, q_ext, nxt_ext, term_ext;

  // Next count value and terminal count for the latched modulus/direction
  always_comb begin
    m_ext    = (mod_q == '0) ? FULL_MOD : {1'b0, mod_q};
    q_ext    = {1'b0, bus.q_vec};
    nxt_ext  = '0;
    term_ext = '0;
    if (dir_q) begin
      nxt_ext  = (q_ext >= m_ext - ONE) ? '0 : q_ext + ONE;
      term_ext = m_ext - ONE;
    end else begin
      nxt_ext  = (q_ext == '0 || q_ext >= m_ext) ? m_ext - ONE : q_ext - ONE;
      term_ext = '0;
    end
  end

  // State and latched configuration registers
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      mod_q      <= '0;
      dir_q      <= 1'b0;
      one_shot_q <= 1'b0;
      load_q     <= '0;
    end else begin
      state_q    <= state_d;
      mod_q      <= mod_d;
      dir_q      <= dir_d;
      one_shot_q <= one_shot_d;
      load_q     <= load_d;
    end
  end

  // Next-state, latching and toggle-enable decode
  always_comb begin
    state_d       = state_q;
    mod_d         = mod_q;
    dir_d         = dir_q;
    one_shot_d    = one_shot_q;
    load_d        = load_q;
    bus.t_vec     = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.tff_clear = clear;

    unique case (state_q)
      IDLE: begin
        // load beats a simultaneous start
        if (bus.load) begin
          load_d  = bus.load_val;
          state_d = LOAD;
        end else if (bus.start) begin
          mod_d      = bus.mod_val;
          dir_d      = bus.dir;
          one_shot_d = bus.one_shot;
          state_d    = RUN;
        end
      end
      LOAD: begin
        bus.busy  = 1'b1;
        bus.t_vec = bus.q_vec ^ load_q;
        state_d   = IDLE;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (bus.stop) begin
          state_d = IDLE;
        end else if (one_shot_q && q_ext == term_ext) begin
          state_d = DONE;
        end else begin
          bus.t_vec = bus.q_vec ^ nxt_ext[WIDTH-1:0];
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The bank is cleared on this same edge; no toggles may leak through.
    if (clear) begin
      bus.t_vec = '0;
      state_d   = IDLE;
    end
  end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Bench: sequencer driving a 4-cell T_FF bank model, directed vector table
// plus hand-written reset and mid-run clear sequences.
module tb_tff_count_sequencer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             clear;
  logic             preset;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] q;

  int n_chk  = 0;
  int n_fail = 0;

  tff_count_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  tff_count_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // T_FF bank: each cell toggles when its t is high; preset lets the bench
  // put an arbitrary value in the bank before the first reset.
  always @(posedge clk) begin
    if (preset)              q <= seed;
    else if (ifc.tff_clear)  q <= '0;
    else                     q <= q ^ ifc.t_vec;
  end
  assign ifc.q_vec = q;

  typedef struct {
    logic             clr;
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_val;
    logic             dir;
    logic             one_shot;
    logic [WIDTH-1:0] exp_q;
    logic             exp_busy;
    logic             exp_done;
    string            name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic clr, input logic st, input logic sp,
                     input logic ld, input logic [3:0] lv, input logic [3:0] mv,
                     input logic dr, input logic os,
                     input logic [3:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.name = name; v.clr = clr; v.start = st; v.stop = sp; v.load = ld;
    v.load_val = lv; v.mod_val = mv; v.dir = dr; v.one_shot = os;
    v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic st, input logic sp, input logic ld,
                       input logic [3:0] lv, input logic [3:0] mv, input logic dr,
                       input logic os);
    clear = clr; ifc.start = st; ifc.stop = sp; ifc.load = ld;
    ifc.load_val = lv; ifc.mod_val = mv; ifc.dir = dr; ifc.one_shot = os;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] eq, input logic eb,
                         input logic ed);
    chk({name, " q"},    32'(q),        32'(eq));
    chk({name, " busy"}, 32'(ifc.busy), 32'(eb));
    chk({name, " done"}, 32'(ifc.done), 32'(ed));
  endtask

  initial begin
    //  name          clr st sp ld lv    mv    dr os   q     busy done
    add("load_a0",    0, 0, 0, 1, 4'hA, 4'h0, 0, 0,  4'h0, 1, 0);
    add("load_a1",    0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'hA, 0, 0);
    add("clr_to0",    1, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 0, 0);
    add("up_start",   0, 1, 0, 0, 4'h0, 4'd5, 1, 0,  4'h0, 1, 0);
    add("up_1",       0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h1, 1, 0);
    add("up_2",       0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h2, 1, 0);
    add("up_3",       0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h3, 1, 0);
    add("up_4",       0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h4, 1, 0);
    add("up_wrap0",   0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 1, 0);
    add("up_1b",      0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h1, 1, 0);
    add("up_stop",    0, 0, 1, 0, 4'h0, 4'h0, 0, 0,  4'h1, 0, 0);
    add("up_frozen",  0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h1, 0, 0);
    add("load3_0",    0, 0, 0, 1, 4'h3, 4'h0, 0, 0,  4'h1, 1, 0);
    add("load3_1",    0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h3, 0, 0);
    add("dn_start",   0, 1, 0, 0, 4'h0, 4'h0, 0, 1,  4'h3, 1, 0);
    add("dn_2",       0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h2, 1, 0);
    add("dn_1",       0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h1, 1, 0);
    add("dn_0",       0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 1, 0);
    add("dn_done",    0, 1, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 0, 1);
    add("dn_idle",    0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 0, 0);
    add("dn_hold",    0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 0, 0);
    add("loadF_0",    0, 0, 0, 1, 4'hF, 4'h0, 0, 0,  4'h0, 1, 0);
    add("loadF_1",    0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'hF, 0, 0);
    add("full_start", 0, 1, 0, 0, 4'h0, 4'h0, 1, 0,  4'hF, 1, 0);
    add("full_wrap",  0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 1, 0);
    add("full_stop",  0, 0, 1, 0, 4'h0, 4'h0, 0, 0,  4'h0, 0, 0);
    add("loadC_0",    0, 0, 0, 1, 4'hC, 4'h0, 0, 0,  4'h0, 1, 0);
    add("loadC_1",    0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'hC, 0, 0);
    add("oor_start",  0, 1, 0, 0, 4'h0, 4'd6, 1, 0,  4'hC, 1, 0);
    add("oor_to0",    0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 1, 0);
    add("oor_stop",   0, 0, 1, 0, 4'h0, 4'h0, 0, 0,  4'h0, 0, 0);
    add("sim_ldst",   0, 1, 0, 1, 4'h5, 4'd3, 1, 0,  4'h0, 1, 0);
    add("sim_q5",     0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h5, 0, 0);
    add("sim_nocnt",  0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h5, 0, 0);

    // Put a random nonzero value in the bank, then reset.
    drive(0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    seed   = 4'($urandom_range(1, 15));
    preset = 1'b1;
    tick();
    preset = 1'b0;
    clear  = 1'b1;
    tick();
    chk("reset q", 32'(q), 32'h0);
    chk("reset t_vec", 32'(ifc.t_vec), 32'h0);
    chk("reset tff_clear", 32'(ifc.tff_clear), 32'h1);
    chk_out("reset", 4'h0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].start, vecs[i].stop, vecs[i].load,
            vecs[i].load_val, vecs[i].mod_val, vecs[i].dir, vecs[i].one_shot);
      tick();
      chk_out(vecs[i].name, vecs[i].exp_q, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Clear in the middle of a run: toggles stop combinationally, bank zeroed.
    drive(0, 1, 0, 0, 4'h0, 4'h0, 1, 0);
    tick();
    chk_out("abort_start", 4'h5, 1'b1, 1'b0);
    drive(0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    tick();
    chk_out("abort_q6", 4'h6, 1'b1, 1'b0);
    chk("abort t_vec running", 32'(ifc.t_vec), 32'h1);
    clear = 1'b1;
    #1;
    chk("abort t_vec on clear", 32'(ifc.t_vec), 32'h0);
    tick();
    chk_out("abort_cleared", 4'h0, 1'b0, 1'b0);
    clear = 1'b0;
    tick();
    chk_out("abort_idle", 4'h0, 1'b0, 1'b0);
    chk("abort idle t_vec", 32'(ifc.t_vec), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
